// File: rtl/seq_div.sv
// seq_div: iterative unsigned restoring divider, one quotient bit per clock
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                request, accepted only while ready=1
//   dividend, divisor    operands captured on the accept edge
//   ready                high in IDLE
//   done                 one-cycle pulse when results load
//   quotient, remainder  held results
//   div_by_zero          set with results when the captured divisor was 0
module seq_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, rem_nxt, quo_nxt;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] shifted, trial;
   logic neg, last, accept;
   // The dividend register doubles as the quotient register: quotient bits
   // shift in at the bottom as dividend bits leave at the top.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial = shifted - {1'b0, dvs_q};
   // A set top bit means shifted exceeds any divisor, so the trial cannot be
   // negative; otherwise the (WIDTH+1)-bit sign bit is exact.
   assign neg = ~shifted[WIDTH] & trial[WIDTH];
   assign rem_nxt = neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nxt = {dvd_q[WIDTH-2:0], ~neg};
   assign last = (state == CALC) && (cnt == CW'(1));
   assign accept = (state == IDLE) && start;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      ready = (state == IDLE);
      done = (state == DONE);
      state_nxt = accept ? ((divisor == '0) ? DONE : CALC) :
                  last ? DONE :
                  (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt <= '0;
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         dvd_q <= dividend;
         dvs_q <= divisor;
         rem_q <= '0;
         cnt <= CW'(WIDTH);
         if (divisor == '0) begin
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         dvd_q <= quo_nxt;
         rem_q <= rem_nxt;
         cnt <= cnt - CW'(1);
         if (last) begin
            quotient <= quo_nxt;
            remainder <= rem_nxt;
            div_by_zero <= 1'b0;
         end
      end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized self-checking bench for seq_div against an arithmetic model
module tb_seq_div;
   localparam int W = 8;
   logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic ready, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   int checks = 0, errors = 0;

   seq_div #(.WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .dividend(dividend), .divisor(divisor),
      .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_result(input int a, input int b, input int lat);
      int q, r;
      q = (b == 0) ? (1 << W) - 1 : a / b;
      r = (b == 0) ? a : a % b;
      chk("latency", lat, (b == 0) ? 1 : W + 1);
      chk("quotient", quotient, q);
      chk("remainder", remainder, r);
      chk("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
      if (b != 0) begin
         chk("identity", 32'(quotient) * 32'(b) + 32'(remainder), a);
         chk("rem_lt_div", 32'(remainder < W'(b)), 1);
      end
   endtask

   // Counts edges from the accept edge (counted as 1) until done is seen high.
   task automatic wait_done(input bit inject, output int lat);
      lat = 1;
      while (lat < 40) begin
         @(negedge clk);
         if (done) break;
         if (inject && lat == 3) begin
            start = 1'b1;
            dividend = 9;
            divisor = 3;
         end else start = 1'b0;
         @(posedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", done, 1);
   endtask

   task automatic run_div(input int a, input int b, input bit inject);
      int lat;
      @(negedge clk);
      chk("ready_idle", ready, 1);
      dividend = W'(a);
      divisor = W'(b);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ready_drop", ready, 0);
      dividend = W'($urandom);
      divisor = W'($urandom);
      wait_done(inject, lat);
      check_result(a, b, lat);
      @(negedge clk);
      chk("done_width", done, 0);
      chk("ready_back", ready, 1);
   endtask

   initial begin
      logic [W-1:0] sp [3] = '{8'd0, 8'd1, 8'd255};
      int lat, n, a, b;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      run_div(100, 7, 0);

      // back-to-back with start held high
      @(negedge clk);
      dividend = 255;
      divisor = 1;
      start = 1'b1;
      @(posedge clk);
      #1;
      dividend = 5;
      divisor = 9;
      chk("b2b_ready_drop", ready, 0);
      lat = 1;
      while (lat < 40) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk);
         lat++;
      end
      check_result(255, 1, lat);
      @(posedge clk);
      #1;
      chk("b2b_done_width", done, 0);
      chk("b2b_ready", ready, 1);
      @(posedge clk);
      #1;
      chk("b2b_second_accept", ready, 0);
      start = 1'b0;
      wait_done(0, lat);
      check_result(5, 9, lat);
      @(negedge clk);
      chk("b2b_done_width2", done, 0);

      run_div(200, 0, 0);
      run_div(50, 5, 0);
      run_div(100, 7, 1);

      // reset in the middle of a calculation
      @(negedge clk);
      dividend = 100;
      divisor = 7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_quotient", quotient, 0);
      chk("mid_rst_remainder", remainder, 0);
      chk("mid_rst_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("mid_rst_no_done", n, 0);
      run_div(64, 8, 0);

      for (int i = 0; i < 1000; i++) begin
         a = ($urandom_range(0, 3) == 0) ? int'(sp[$urandom_range(0, 2)]) : int'($urandom_range(0, 255));
         b = ($urandom_range(0, 3) == 0) ? int'(sp[$urandom_range(0, 2)]) : int'($urandom_range(0, 255));
         run_div(a, b, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
